uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-002 The block SHALL have parameter PARITY_MODE, default 1, meaning 0 none, 1 even, 2 odd.
REQ-003 The block SHALL have parameter OVERSAMPLE, default 16, meaning baud_tick pulses per bit, even and at least 8.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port baud_tick, input, 1 bit: single-cycle enable at OVERSAMPLE x baud rate.
REQ-007 The block SHALL have port rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-008 The block SHALL have port dout, output, DATA_BITS wide: received data, LSB first on the line.
REQ-009 The block SHALL have port out_valid, output, 1 bit: dout and the error flags are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the current frame.
REQ-011 The block SHALL have port parity_err, output, 1 bit: the parity check failed for the presented frame.
REQ-012 The block SHALL have port frame_err, output, 1 bit: the stop bit sampled low for the presented frame.
REQ-013 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed frame is dropped.
REQ-014 The block SHALL have port brk, output, 1 bit: one-cycle pulse when a break is detected.

Function
REQ-015 The block SHALL pass rxd through a 2-flop synchroniser; all later references to rxd mean the synchronised value.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; tick_cnt (0..OVERSAMPLE-1) advances only on baud_tick.
REQ-017 IDLE->START SHALL occur on a baud_tick with rxd=0; tick_cnt SHALL clear to 0 on that transition.
REQ-018 In START at tick_cnt=OVERSAMPLE/2-1: rxd=0 -> DATA with tick_cnt=0 (mid-bit alignment); rxd=1 -> IDLE (glitch rejected, no outputs).
REQ-019 DATA, PARITY and STOP SHALL sample rxd at tick_cnt=OVERSAMPLE-1, i.e. mid-bit, then clear tick_cnt.
REQ-020 DATA SHALL shift right into the MSB and leave after DATA_BITS samples: to PARITY if PARITY_MODE!=0, else to STOP.
REQ-021 Expected parity SHALL be XOR of the data bits (even), or its inverse (odd); a mismatch sets the frame's parity_err.
REQ-022 STOP SHALL sample once; stop=0 sets frame_err; the FSM returns to IDLE on the sample tick, allowing back-to-back frames.
REQ-023 On the clk after the stop sample, dout, parity_err and frame_err SHALL load together and out_valid SHALL assert, giving 1-cycle completion latency.
REQ-024 out_valid, dout and the flags SHALL hold until a cycle with out_valid=1 and out_ready=1; out_valid SHALL then clear on the next clk.
REQ-025 Completion while out_valid=1 and out_ready=0 SHALL drop the new frame, keep the old one, and pulse overrun for 1 cycle.
REQ-026 Completion in the same cycle as acceptance SHALL load the new frame with out_valid kept at 1 and no overrun.
REQ-027 baud_tick pulses while out_valid is high SHALL not stall reception.

Reset
REQ-028 On rst=0 the FSM SHALL go to IDLE and tick_cnt and the bit count SHALL clear.
REQ-029 On rst=0 the synchroniser flops SHALL reset to 1.
REQ-030 On rst=0 dout=0, out_valid=0, parity_err=0, frame_err=0, overrun=0 and brk=0.
REQ-031 Reset mid-frame SHALL discard the partial frame; after release, reception SHALL restart only on a fresh falling edge seen in IDLE.

Configuration
REQ-032 With macro UART_RX_BREAK_DET_EN defined, a frame with all data bits 0, parity 0 (if present) and stop 0 SHALL pulse brk for 1 cycle instead of setting out_valid.
REQ-033 After a break, the FSM SHALL wait in IDLE until rxd=1 before accepting a new start bit.
REQ-034 With UART_RX_BREAK_DET_EN undefined, brk SHALL be tied 0 and a break frame SHALL be delivered as a normal frame with frame_err=1.

Verification
REQ-035 Defaults, frame 0xA5 with even parity bit 0 and stop 1, out_ready=1 -> dout=0xA5, out_valid pulses 1 cycle, parity_err=0, frame_err=0.
REQ-036 rxd low for 4 ticks then high -> no out_valid, FSM back in IDLE; a following 0x3C frame is received correctly.
REQ-037 0x01 sent with parity bit 0 (even mode) -> out_valid=1, dout=0x01, parity_err=1; with stop=0 -> frame_err=1.
REQ-038 out_ready=0, frames 0x11 then 0x22 -> dout stays 0x11, overrun pulses once; out_ready=1 then clears out_valid.
REQ-039 DATA_BITS=7, PARITY_MODE=2, frame 0x55 with parity bit 1 -> dout=0x55, parity_err=0.
REQ-040 rst=0 asserted mid DATA, then a 0xF0 frame -> outputs 0 during reset, then dout=0xF0; with UART_RX_BREAK_DET_EN, an all-zero frame -> brk=1, out_valid=0.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param
//   Oversampling UART receiver. The serial line is synchronised, the start bit
//   is qualified at its middle, and every following bit is sampled once at its
//   middle. A completed frame is presented on a valid/ready output register
//   together with its parity and framing error flags.
//
//   Parameters
//     DATA_BITS   : data bits per frame, 5..9
//     PARITY_MODE : 0 none, 1 even, 2 odd
//     OVERSAMPLE  : baud_tick pulses per bit, even and >= 8
//
//   Ports
//     clk        : clock, rising edge
//     rst        : asynchronous active-low reset
//     baud_tick  : one-cycle enable at OVERSAMPLE x baud rate
//     rxd        : asynchronous serial input, idle high
//     dout       : received data (first bit on the line is the LSB)
//     out_valid  : dout / parity_err / frame_err hold a frame
//     out_ready  : consumer accepts the presented frame
//     parity_err : parity mismatch for the presented frame
//     frame_err  : stop bit sampled low for the presented frame
//     overrun    : one-cycle pulse when a completed frame is dropped
//     brk        : one-cycle pulse when a break frame is detected
//
//   Build option
//     UART_RX_BREAK_DET_EN : when defined, an all-zero frame with a low stop
//     bit raises brk instead of being delivered, and reception then waits for
//     the line to return high. When undefined, brk is tied low and such a
//     frame is delivered normally with frame_err set.
//
//   state  | meaning
//   IDLE   | line idle, waiting for a low sample on a baud tick
//   START  | counting to the middle of the start bit to qualify it
//   DATA   | sampling DATA_BITS data bits, one per bit period
//   PARITY | sampling the parity bit
//   STOP   | sampling the stop bit, then back to IDLE

module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 brk
);

  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // synchroniser
  logic rxd_s1_q, rxd_s1_d;
  logic rxd_s2_q, rxd_s2_d;

  // receive FSM
  state_t                 state_q, state_d;
  logic [TCW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_bit_q, par_bit_d;

  // completed frame, one cycle ahead of the output register
  logic                   done_q, done_d;
  logic [DATA_BITS-1:0]   frm_data_q, frm_data_d;
  logic                   frm_perr_q, frm_perr_d;
  logic                   frm_ferr_q, frm_ferr_d;

  // output register
  logic [DATA_BITS-1:0]   dout_q, dout_d;
  logic                   out_valid_q, out_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;

`ifdef UART_RX_BREAK_DET_EN
  logic                   frm_brk_q, frm_brk_d;
  logic                   brk_wait_q, brk_wait_d;
  logic                   brk_q, brk_d;
`endif

  logic rxd_sync;
  logic tick_last;
  logic tick_half;
  logic bits_done;
  logic exp_par;
  logic perr_calc;
  logic brk_calc;

  assign rxd_sync  = rxd_s2_q;
  assign tick_last = (tick_cnt_q == TCW'(OVERSAMPLE - 1));
  assign tick_half = (tick_cnt_q == TCW'(OVERSAMPLE / 2 - 1));
  assign bits_done = (bit_cnt_q == BCW'(DATA_BITS - 1));

  // Parity is judged from the assembled data and the sampled parity bit,
  // evaluated while the stop bit is being sampled.
  assign exp_par   = (PARITY_MODE == 2) ? ~(^shift_q) : (^shift_q);
  assign perr_calc = (PARITY_MODE != 0) && (par_bit_q != exp_par);
  assign brk_calc  = (shift_q == '0) && ((PARITY_MODE == 0) || !par_bit_q) && !rxd_sync;

  always_comb begin
    rxd_s1_d     = rxd;
    rxd_s2_d     = rxd_s1_q;

    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;

    done_d       = 1'b0;
    frm_data_d   = frm_data_q;
    frm_perr_d   = frm_perr_q;
    frm_ferr_d   = frm_ferr_q;

    dout_d       = dout_q;
    out_valid_d  = out_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;

`ifdef UART_RX_BREAK_DET_EN
    frm_brk_d    = frm_brk_q;
    brk_wait_d   = brk_wait_q;
    brk_d        = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef UART_RX_BREAK_DET_EN
        // after a break the line must go high before a new start is accepted
        if (brk_wait_q) begin
          if (rxd_sync) brk_wait_d = 1'b0;
        end else
`endif
        if (baud_tick && !rxd_sync) begin
          state_d    = S_START;
          tick_cnt_d = '0;
        end
      end

      S_START: begin
        if (baud_tick) begin
          if (tick_half) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rxd_sync ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          if (tick_last) begin
            tick_cnt_d = '0;
            shift_d    = {rxd_sync, shift_q[DATA_BITS-1:1]};
            if (bits_done) begin
              bit_cnt_d = '0;
              state_d   = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end

      S_PARITY: begin
        if (baud_tick) begin
          if (tick_last) begin
            tick_cnt_d = '0;
            par_bit_d  = rxd_sync;
            state_d    = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end

      S_STOP: begin
        if (baud_tick) begin
          if (tick_last) begin
            tick_cnt_d = '0;
            state_d    = S_IDLE;
            done_d     = 1'b1;
            frm_data_d = shift_q;
            frm_perr_d = perr_calc;
            frm_ferr_d = !rxd_sync;
`ifdef UART_RX_BREAK_DET_EN
            frm_brk_d  = brk_calc;
            brk_wait_d = brk_calc;
`endif
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end

      default: begin
        state_d    = S_IDLE;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase

    // Output handshake. Acceptance clears out_valid; a completion in the same
    // cycle as acceptance reloads it, while a completion against a held,
    // unaccepted frame is dropped and reported as overrun.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (done_q) begin
`ifdef UART_RX_BREAK_DET_EN
      if (frm_brk_q) brk_d = 1'b1;
      else
`endif
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end else begin
        dout_d       = frm_data_q;
        parity_err_d = frm_perr_q;
        frame_err_d  = frm_ferr_q;
        out_valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_s1_q     <= 1'b1;
      rxd_s2_q     <= 1'b1;
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      done_q       <= 1'b0;
      frm_data_q   <= '0;
      frm_perr_q   <= 1'b0;
      frm_ferr_q   <= 1'b0;
      dout_q       <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      frm_brk_q    <= 1'b0;
      brk_wait_q   <= 1'b0;
      brk_q        <= 1'b0;
`endif
    end else begin
      rxd_s1_q     <= rxd_s1_d;
      rxd_s2_q     <= rxd_s2_d;
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      done_q       <= done_d;
      frm_data_q   <= frm_data_d;
      frm_perr_q   <= frm_perr_d;
      frm_ferr_q   <= frm_ferr_d;
      dout_q       <= dout_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_BREAK_DET_EN
      frm_brk_q    <= frm_brk_d;
      brk_wait_q   <= brk_wait_d;
      brk_q        <= brk_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign out_valid  = out_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

`ifdef UART_RX_BREAK_DET_EN
  assign brk = brk_q;
`else
  // break detection is not built; brk_calc only matters when it is
  logic unused_brk_calc;
  assign unused_brk_calc = brk_calc;
  assign brk = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

  localparam int OS = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic baud_tick = 1'b0;
  logic rxd = 1'b1;
  logic rxd7 = 1'b1;
  logic out_ready = 1'b1;

  logic [7:0] dout;
  logic       out_valid, parity_err, frame_err, overrun, brk;
  logic [6:0] dout7;
  logic       out_valid7, parity_err7, frame_err7, overrun7, brk7;

  always #5 clk = ~clk;

  // baud tick every third clock, changed on the falling edge
  int div = 0;
  always @(negedge clk) begin
    div = (div == 2) ? 0 : div + 1;
    baud_tick = (div == 2);
  end

  uart_rx_param dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rxd(rxd),
    .dout(dout), .out_valid(out_valid), .out_ready(out_ready),
    .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .brk(brk)
  );

  uart_rx_param #(.DATA_BITS(7), .PARITY_MODE(2), .OVERSAMPLE(16)) dut7 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rxd(rxd7),
    .dout(dout7), .out_valid(out_valid7), .out_ready(1'b1),
    .parity_err(parity_err7), .frame_err(frame_err7),
    .overrun(overrun7), .brk(brk7)
  );

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t q8[$];
  exp_t q7[$];

  int n_cmp = 0;
  int n_fail = 0;
  int ovr_seen = 0, exp_ovr = 0, brk_seen = 0, exp_brk = 0;
  int ovr7_seen = 0, brk7_seen = 0;
  logic [8:0] last_dout = '0, last7_dout = '0;
  logic       last_perr = 1'b0, last_ferr = 1'b0, last7_perr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: what a frame on the line must produce.
  function automatic exp_t model(input logic [8:0] d, input int nbits, input int pmode,
                                 input logic pbit, input logic stop);
    exp_t e;
    int   ones;
    logic ep;
    e.data = d & 9'((1 << nbits) - 1);
    ones   = $countones(e.data);
    ep     = (pmode == 1) ? ones[0] : ~ones[0];
    e.perr = (pmode != 0) && (pbit != ep);
    e.ferr = !stop;
    return e;
  endfunction

  function automatic bit is_break(input logic [8:0] d, input int nbits, input int pmode,
                                  input logic pbit, input logic stop);
    return ((d & 9'((1 << nbits) - 1)) == 0) && (pmode == 0 || pbit == 1'b0) && (stop == 1'b0);
  endfunction

  // Compare process: every cycle a frame is presented it must be the oldest
  // expected one; acceptance retires it.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid) begin
        if (q8.size() == 0) chk("valid_without_frame", out_valid, 0);
        else begin
          chk("dout", dout, q8[0].data);
          chk("parity_err", parity_err, q8[0].perr);
          chk("frame_err", frame_err, q8[0].ferr);
          if (out_ready) begin
            last_dout = dout;
            last_perr = parity_err;
            last_ferr = frame_err;
            void'(q8.pop_front());
          end
        end
      end
      if (out_valid7) begin
        if (q7.size() == 0) chk("valid7_without_frame", out_valid7, 0);
        else begin
          chk("dout7", dout7, q7[0].data);
          chk("parity_err7", parity_err7, q7[0].perr);
          chk("frame_err7", frame_err7, q7[0].ferr);
          last7_dout = 9'(dout7);
          last7_perr = parity_err7;
          void'(q7.pop_front());
        end
      end
      if (overrun)  ovr_seen++;
      if (brk)      brk_seen++;
      if (overrun7) ovr7_seen++;
      if (brk7)     brk7_seen++;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
  endtask

  task automatic drive_line(input int sel, input logic v);
    @(negedge clk);
    if (sel == 0) rxd = v;
    else          rxd7 = v;
  endtask

  task automatic send_bit(input int sel, input logic v);
    drive_line(sel, v);
    wait_ticks(OS);
  endtask

  task automatic frame_head(input int sel, input logic [8:0] d, input int nbits,
                            input int pmode, input logic pbit);
    wait_ticks(1);
    send_bit(sel, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(sel, d[i]);
    if (pmode != 0) send_bit(sel, pbit);
  endtask

  task automatic expect_frame(input int sel, input logic [8:0] d, input int nbits,
                              input int pmode, input logic pbit, input logic stop,
                              input bit drop);
    bit b;
    b = 1'b0;
    if (drop) exp_ovr++;
    else begin
`ifdef UART_RX_BREAK_DET_EN
      b = is_break(d, nbits, pmode, pbit, stop);
`endif
      if (b) exp_brk++;
      else if (sel == 0) q8.push_back(model(d, nbits, pmode, pbit, stop));
      else               q7.push_back(model(d, nbits, pmode, pbit, stop));
    end
  endtask

  task automatic send_frame(input int sel, input logic [8:0] d, input int nbits,
                            input int pmode, input logic pbit, input logic stop,
                            input bit drop, input int idle);
    expect_frame(sel, d, nbits, pmode, pbit, stop, drop);
    frame_head(sel, d, nbits, pmode, pbit);
    send_bit(sel, stop);
    if (idle > 0) begin
      drive_line(sel, 1'b1);
      wait_ticks(idle);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_perr"}, parity_err, 0);
    chk({tag, "_ferr"}, frame_err, 0);
    chk({tag, "_ovr"}, overrun, 0);
    chk({tag, "_brk"}, brk, 0);
  endtask

  int cnt;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b1;
    wait_ticks(4);

    // 0xA5, even parity bit 0: latency and one-cycle valid pulse
    expect_frame(0, 9'hA5, 8, 1, 1'b0, 1'b1, 1'b0);
    frame_head(0, 9'hA5, 8, 1, 1'b0);
    drive_line(0, 1'b1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < 60);
    chk("a5_latency", cnt, 28);
    @(negedge clk);
    chk("a5_pulse", out_valid, 0);
    wait_ticks(8);
    chk("a5_dout", last_dout, 9'hA5);
    chk("a5_perr", last_perr, 0);
    chk("a5_ferr", last_ferr, 0);

    // short glitch rejected, then 0x3C
    wait_ticks(1);
    drive_line(0, 1'b0);
    wait_ticks(4);
    drive_line(0, 1'b1);
    wait_ticks(16);
    send_frame(0, 9'h3C, 8, 1, 1'b0, 1'b1, 1'b0, 0);
    chk("glitch_then_3c", last_dout, 9'h3C);

    // parity and framing errors
    send_frame(0, 9'h01, 8, 1, 1'b0, 1'b1, 1'b0, 0);
    chk("perr_01", last_perr, 1);
    send_frame(0, 9'h01, 8, 1, 1'b1, 1'b0, 1'b0, 16);
    chk("ferr_01", last_ferr, 1);
    chk("ferr_01_perr", last_perr, 0);

    // overrun: 0x11 held, 0x22 dropped
    @(posedge clk); #1 out_ready = 1'b0;
    send_frame(0, 9'h11, 8, 1, 1'b0, 1'b1, 1'b0, 0);
    send_frame(0, 9'h22, 8, 1, 1'b0, 1'b1, 1'b1, 0);
    wait_ticks(2);
    chk("ovr_dout", dout, 8'h11);
    chk("ovr_valid", out_valid, 1);
    chk("ovr_count", ovr_seen, 1);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ovr_clear", out_valid, 0);

    // completion in the acceptance cycle: new frame loads, no overrun
    @(posedge clk); #1 out_ready = 1'b0;
    send_frame(0, 9'h5A, 8, 1, 1'b0, 1'b1, 1'b0, 0);
    expect_frame(0, 9'h69, 8, 1, 1'b0, 1'b1, 1'b0);
    frame_head(0, 9'h69, 8, 1, 1'b0);
    drive_line(0, 1'b1);
    repeat (26) @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("same_cycle_valid", out_valid, 1);
    chk("same_cycle_dout", dout, 8'h69);
    chk("same_cycle_ovr", ovr_seen, 1);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_ticks(8);

    // 7 data bits, odd parity
    send_frame(1, 9'h55, 7, 2, 1'b1, 1'b1, 1'b0, 0);
    chk("odd7_dout", last7_dout, 9'h55);
    chk("odd7_perr", last7_perr, 0);
    send_frame(1, 9'h55, 7, 2, 1'b0, 1'b1, 1'b0, 0);
    chk("odd7_bad_perr", last7_perr, 1);

    // reset in the middle of the data bits
    wait_ticks(1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    wait_ticks(5);
    @(posedge clk); #1 rst = 1'b0; rxd = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("midreset");
    @(posedge clk); #1 rst = 1'b1;
    wait_ticks(4);
    send_frame(0, 9'hF0, 8, 1, 1'b0, 1'b1, 1'b0, 0);
    chk("after_reset_f0", last_dout, 9'hF0);

    // break frame: all zero, parity 0, stop 0
    send_frame(0, 9'h00, 8, 1, 1'b0, 1'b0, 1'b0, 16);
`ifdef UART_RX_BREAK_DET_EN
    chk("break_pulse", brk_seen, 1);
`else
    chk("break_as_frame_ferr", last_ferr, 1);
    chk("break_as_frame_dout", last_dout, 0);
`endif
    send_frame(0, 9'h3C, 8, 1, 1'b0, 1'b1, 1'b0, 0);
    chk("after_break_3c", last_dout, 9'h3C);

    wait_ticks(4);
    chk("queue8_drained", q8.size(), 0);
    chk("queue7_drained", q7.size(), 0);
    chk("overrun_total", ovr_seen, exp_ovr);
    chk("brk_total", brk_seen, exp_brk);
    chk("overrun7_total", ovr7_seen, 0);
    chk("brk7_total", brk7_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
